// File: rtl/cim_array_sequencer_if.sv
// Host command channel plus the select/enable bundle driven into the CIM macro.
// The slave side is the sequencer; the master side is the host/array view.
interface cim_array_sequencer_if #(
  parameter int N_BANK = 16,
  parameter int N_COL  = 8,
  parameter int DATA_W = 16
) ();
  localparam int BW = $clog2(N_BANK);
  localparam int CW = $clog2(N_COL);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        op_code;
  logic [BW-1:0]     addr_bank;
  logic [CW-1:0]     addr_col;
  logic [DATA_W-1:0] data;

  logic              mac_en;
  logic              w_en;
  logic [DATA_W-1:0] data_op;
  logic [N_BANK-1:0] bank_mux;
  logic [N_COL-1:0]  col_mux;
  logic [CW-1:0]     cur_col;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, op_code, addr_bank, addr_col, data,
    input  cmd_ready, mac_en, w_en, data_op, bank_mux, col_mux, cur_col, busy, done, err
  );

  modport slave (
    input  cmd_valid, op_code, addr_bank, addr_col, data,
    output cmd_ready, mac_en, w_en, data_op, bank_mux, col_mux, cur_col, busy, done, err
  );
endinterface

// File: rtl/cim_array_sequencer.sv
// Sequences read/write/search/sweep commands onto the CIM array, holding each op
// for a programmable cycle count; ready only while idle, one done/err pulse per op.
module cim_array_sequencer #(
  parameter int N_BANK     = 16,
  parameter int N_COL      = 8,
  parameter int DATA_W     = 16,
  parameter int WORD_W     = 8,
  parameter int QUERY_W    = 4,
  parameter int READ_CYC   = 1,
  parameter int WRITE_CYC  = 2,
  parameter int SEARCH_CYC = 1
) (
  input logic                  clk,
  input logic                  rst,
  cim_array_sequencer_if.slave bus
);
  localparam int CW     = $clog2(N_COL);
  localparam int MAX_RW = (READ_CYC > WRITE_CYC) ? READ_CYC : WRITE_CYC;
  localparam int MAX_C  = (MAX_RW > SEARCH_CYC) ? MAX_RW : SEARCH_CYC;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sweep;
  logic             err_pend;
  logic             accept;
  logic             bank_oor;
  logic             col_oor;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bank_oor      = 32'(bus.addr_bank) >= N_BANK;
  assign col_oor       = 32'(bus.addr_col) >= N_COL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sweep        <= 1'b0;
      err_pend     <= 1'b0;
      bus.mac_en   <= 1'b1;
      bus.w_en     <= 1'b0;
      bus.data_op  <= '0;
      bus.bank_mux <= '0;
      bus.col_mux  <= '0;
      bus.cur_col  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ACTIVE;
            bus.busy <= 1'b1;
            sweep    <= 1'b0;
            err_pend <= 1'b0;
            case (bus.op_code)
              2'b00: begin
                cnt          <= CNT_W'(READ_CYC - 1);
                bus.bank_mux <= '1;
                bus.col_mux  <= '1;
                bus.data_op  <= bus.data;
              end
              2'b01: begin
                cnt <= CNT_W'(WRITE_CYC - 1);
                // An out-of-range target leaves the array untouched but still takes the full slot.
                if (bank_oor) begin
                  err_pend <= 1'b1;
                end else begin
                  bus.bank_mux <= N_BANK'(1) << bus.addr_bank;
                  bus.w_en     <= 1'b1;
                  bus.data_op  <= DATA_W'(bus.data[WORD_W-1:0]);
                end
              end
              2'b10: begin
                cnt <= CNT_W'(SEARCH_CYC - 1);
                if (col_oor) begin
                  err_pend <= 1'b1;
                end else begin
                  bus.bank_mux <= '1;
                  bus.col_mux  <= N_COL'(1) << bus.addr_col;
                  bus.mac_en   <= 1'b0;
                  bus.data_op  <= DATA_W'(bus.data[QUERY_W-1:0]);
                  bus.cur_col  <= bus.addr_col;
                end
              end
              default: begin
                cnt          <= CNT_W'(SEARCH_CYC - 1);
                sweep        <= 1'b1;
                bus.bank_mux <= '1;
                bus.col_mux  <= N_COL'(1);
                bus.mac_en   <= 1'b0;
                bus.data_op  <= DATA_W'(bus.data[QUERY_W-1:0]);
                bus.cur_col  <= '0;
              end
            endcase
          end
        end
        default: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (sweep && (bus.cur_col != CW'(N_COL - 1))) begin
            cnt         <= CNT_W'(SEARCH_CYC - 1);
            bus.cur_col <= bus.cur_col + CW'(1);
            bus.col_mux <= bus.col_mux << 1;
          end else begin
            state        <= IDLE;
            sweep        <= 1'b0;
            bus.done     <= 1'b1;
            bus.err      <= err_pend;
            bus.busy     <= 1'b0;
            bus.mac_en   <= 1'b1;
            bus.w_en     <= 1'b0;
            bus.data_op  <= '0;
            bus.bank_mux <= '0;
            bus.col_mux  <= '0;
            bus.cur_col  <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cim_array_sequencer.sv
// Directed bench: a power-of-two instance for the main ops and a 12-bank/6-column
// instance for out-of-range addressing.
module tb_cim_array_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  cim_array_sequencer_if #(.N_BANK(16), .N_COL(8), .DATA_W(16)) ia ();
  cim_array_sequencer_if #(.N_BANK(12), .N_COL(6), .DATA_W(16)) ib ();

  cim_array_sequencer #(
    .N_BANK(16), .N_COL(8), .DATA_W(16), .WORD_W(8), .QUERY_W(4),
    .READ_CYC(1), .WRITE_CYC(2), .SEARCH_CYC(2)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));

  cim_array_sequencer #(
    .N_BANK(12), .N_COL(6), .DATA_W(16), .WORD_W(8), .QUERY_W(4),
    .READ_CYC(1), .WRITE_CYC(2), .SEARCH_CYC(1)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  // Presents one command on A for one edge; returns at the negedge of op cycle 1.
  task automatic start_a(input logic [1:0] op, input logic [3:0] bank, input logic [2:0] col,
                         input logic [15:0] d);
    @(negedge clk);
    ia.cmd_valid = 1'b1; ia.op_code = op; ia.addr_bank = bank; ia.addr_col = col; ia.data = d;
    @(negedge clk);
    ia.cmd_valid = 1'b0;
  endtask

  task automatic start_b(input logic [1:0] op, input logic [3:0] bank, input logic [2:0] col,
                         input logic [15:0] d);
    @(negedge clk);
    ib.cmd_valid = 1'b1; ib.op_code = op; ib.addr_bank = bank; ib.addr_col = col; ib.data = d;
    @(negedge clk);
    ib.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    ia.cmd_valid = 1'b1; ia.op_code = 2'b00; ia.data = 16'h1111;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ia.cmd_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready: got %b want 0", ia.cmd_ready); end
    n_checks++;
    if ({ia.busy, ia.mac_en, ia.w_en, ia.done, ia.err} !== 5'b01000) begin
      n_fails++; $display("FAIL reset_flags: got %b want 01000", {ia.busy, ia.mac_en, ia.w_en, ia.done, ia.err});
    end
    n_checks++;
    if ({ia.bank_mux, ia.col_mux, ia.data_op, ia.cur_col} !== 43'd0) begin
      n_fails++; $display("FAIL reset_buses: got %h want 0", {ia.bank_mux, ia.col_mux, ia.data_op, ia.cur_col});
    end
    rst = 1'b0; ia.cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ia.cmd_ready, ia.busy} !== 2'b10) begin n_fails++; $display("FAIL reset_release: got %b want 10", {ia.cmd_ready, ia.busy}); end
  endtask

  task automatic test_read();
    start_a(2'b00, 4'd0, 3'd0, 16'hA5A5);
    n_checks++;
    if ({ia.bank_mux, ia.col_mux, ia.data_op} !== {16'hFFFF, 8'hFF, 16'hA5A5}) begin
      n_fails++; $display("FAIL read_op: got %h want ffffffa5a5", {ia.bank_mux, ia.col_mux, ia.data_op});
    end
    n_checks++;
    if ({ia.busy, ia.cmd_ready, ia.mac_en, ia.w_en, ia.done} !== 5'b10100) begin
      n_fails++; $display("FAIL read_flags: got %b want 10100", {ia.busy, ia.cmd_ready, ia.mac_en, ia.w_en, ia.done});
    end
    @(negedge clk);
    n_checks++;
    if ({ia.done, ia.err, ia.busy, ia.cmd_ready, ia.bank_mux, ia.col_mux, ia.data_op} !== {4'b1001, 40'd0}) begin
      n_fails++; $display("FAIL read_done: got done=%b err=%b busy=%b rdy=%b bank=%h dop=%h",
                          ia.done, ia.err, ia.busy, ia.cmd_ready, ia.bank_mux, ia.data_op);
    end
  endtask

  task automatic test_write();
    start_a(2'b01, 4'd5, 3'd0, 16'h12C3);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      n_checks++;
      if ({ia.bank_mux, ia.col_mux, ia.w_en, ia.mac_en, ia.data_op, ia.done} !== {16'h0020, 8'h00, 2'b11, 16'h00C3, 1'b0}) begin
        n_fails++; $display("FAIL write_cyc%0d: got bank=%h col=%h w_en=%b dop=%h done=%b want 0020 00 1 00c3 0",
                            i, ia.bank_mux, ia.col_mux, ia.w_en, ia.data_op, ia.done);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({ia.done, ia.w_en, ia.busy, ia.bank_mux} !== {3'b100, 16'h0}) begin
      n_fails++; $display("FAIL write_done: got done=%b w_en=%b busy=%b bank=%h", ia.done, ia.w_en, ia.busy, ia.bank_mux);
    end
  endtask

  // Search with cmd_valid left high: must be refused mid-op and accepted in the done cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    ia.cmd_valid = 1'b1; ia.op_code = 2'b10; ia.addr_col = 3'd6; ia.data = 16'hFFF9;
    @(negedge clk);
    ia.op_code = 2'b00; ia.data = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      n_checks++;
      if ({ia.col_mux, ia.bank_mux, ia.mac_en, ia.data_op, ia.cur_col, ia.cmd_ready} !== {8'h40, 16'hFFFF, 1'b0, 16'h0009, 3'd6, 1'b0}) begin
        n_fails++; $display("FAIL search_cyc%0d: got col=%h bank=%h mac=%b dop=%h cur=%0d rdy=%b want 40 ffff 0 0009 6 0",
                            i, ia.col_mux, ia.bank_mux, ia.mac_en, ia.data_op, ia.cur_col, ia.cmd_ready);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({ia.done, ia.cmd_ready, ia.mac_en, ia.col_mux, ia.cur_col} !== {3'b111, 8'h00, 3'd0}) begin
      n_fails++; $display("FAIL search_done: got done=%b rdy=%b mac=%b col=%h cur=%0d", ia.done, ia.cmd_ready, ia.mac_en, ia.col_mux, ia.cur_col);
    end
    @(negedge clk);
    ia.cmd_valid = 1'b0;
    n_checks++;
    if ({ia.busy, ia.done, ia.bank_mux, ia.data_op} !== {2'b10, 16'hFFFF, 16'h1234}) begin
      n_fails++; $display("FAIL b2b_read: got busy=%b done=%b bank=%h dop=%h want 1 0 ffff 1234", ia.busy, ia.done, ia.bank_mux, ia.data_op);
    end
    @(negedge clk);
    n_checks++;
    if (ia.done !== 1'b1) begin n_fails++; $display("FAIL b2b_done: got %b want 1", ia.done); end
  endtask

  task automatic test_sweep();
    int dones;
    dones = 0;
    start_a(2'b11, 4'd0, 3'd5, 16'h00F7);
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (c != 0 || k != 0) @(negedge clk);
        if (ia.done === 1'b1) dones++;
        n_checks++;
        if ({ia.col_mux, ia.cur_col, ia.busy, ia.mac_en, ia.data_op} !== {8'(1 << c), 3'(c), 2'b10, 16'h0007}) begin
          n_fails++; $display("FAIL sweep_c%0d_k%0d: got col=%h cur=%0d busy=%b mac=%b dop=%h", c, k, ia.col_mux, ia.cur_col, ia.busy, ia.mac_en, ia.data_op);
        end
      end
    end
    n_checks++;
    if (dones !== 0) begin n_fails++; $display("FAIL sweep_early_done: got %0d want 0", dones); end
    @(negedge clk);
    n_checks++;
    if ({ia.done, ia.busy, ia.col_mux, ia.cur_col} !== {2'b10, 11'd0}) begin
      n_fails++; $display("FAIL sweep_done: got done=%b busy=%b col=%h cur=%0d", ia.done, ia.busy, ia.col_mux, ia.cur_col);
    end
    @(negedge clk);
    n_checks++;
    if (ia.done !== 1'b0) begin n_fails++; $display("FAIL sweep_single_done: got %b want 0", ia.done); end
  endtask

  task automatic test_out_of_range();
    start_b(2'b01, 4'd13, 3'd0, 16'hBEEF);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      n_checks++;
      if ({ib.w_en, ib.bank_mux, ib.busy, ib.done, ib.err} !== {1'b0, 12'h000, 3'b100}) begin
        n_fails++; $display("FAIL oor_write_cyc%0d: got w_en=%b bank=%h busy=%b done=%b err=%b", i, ib.w_en, ib.bank_mux, ib.busy, ib.done, ib.err);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({ib.done, ib.err, ib.busy} !== 3'b110) begin n_fails++; $display("FAIL oor_write_done: got done/err/busy=%b want 110", {ib.done, ib.err, ib.busy}); end
    @(negedge clk);
    n_checks++;
    if (ib.err !== 1'b0) begin n_fails++; $display("FAIL oor_err_clear: got %b want 0", ib.err); end
    start_b(2'b10, 4'd0, 3'd7, 16'h000A);
    n_checks++;
    if ({ib.col_mux, ib.mac_en, ib.busy, ib.err} !== {6'h00, 3'b110}) begin
      n_fails++; $display("FAIL oor_search: got col=%h mac=%b busy=%b err=%b", ib.col_mux, ib.mac_en, ib.busy, ib.err);
    end
    @(negedge clk);
    n_checks++;
    if ({ib.done, ib.err} !== 2'b11) begin n_fails++; $display("FAIL oor_search_done: got %b want 11", {ib.done, ib.err}); end
    start_b(2'b01, 4'd11, 3'd0, 16'h0055);
    n_checks++;
    if ({ib.bank_mux, ib.w_en, ib.data_op} !== {12'h800, 1'b1, 16'h0055}) begin
      n_fails++; $display("FAIL edge_bank_write: got bank=%h w_en=%b dop=%h want 800 1 0055", ib.bank_mux, ib.w_en, ib.data_op);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ib.done, ib.err} !== 2'b10) begin n_fails++; $display("FAIL edge_bank_done: got %b want 10", {ib.done, ib.err}); end
  endtask

  task automatic test_reset_mid_op();
    start_a(2'b11, 4'd0, 3'd0, 16'h0003);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ia.col_mux !== 8'h02) begin n_fails++; $display("FAIL rstmid_pre: got col=%h want 02", ia.col_mux); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ia.busy, ia.done, ia.err, ia.mac_en, ia.w_en, ia.cmd_ready, ia.col_mux, ia.bank_mux, ia.data_op, ia.cur_col} !== {6'b000100, 43'd0}) begin
      n_fails++; $display("FAIL rstmid_state: got busy=%b done=%b mac=%b rdy=%b col=%h bank=%h dop=%h",
                          ia.busy, ia.done, ia.mac_en, ia.cmd_ready, ia.col_mux, ia.bank_mux, ia.data_op);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ia.done, ia.busy, ia.cmd_ready} !== 3'b001) begin n_fails++; $display("FAIL rstmid_release: got %b want 001", {ia.done, ia.busy, ia.cmd_ready}); end
    start_a(2'b00, 4'd0, 3'd0, 16'h5A5A);
    n_checks++;
    if ({ia.busy, ia.data_op, ia.bank_mux} !== {1'b1, 16'h5A5A, 16'hFFFF}) begin
      n_fails++; $display("FAIL rstmid_read: got busy=%b dop=%h bank=%h", ia.busy, ia.data_op, ia.bank_mux);
    end
    @(negedge clk);
    n_checks++;
    if (ia.done !== 1'b1) begin n_fails++; $display("FAIL rstmid_read_done: got %b want 1", ia.done); end
  endtask

  initial begin
    ia.cmd_valid = 1'b0; ia.op_code = 2'b00; ia.addr_bank = '0; ia.addr_col = '0; ia.data = '0;
    ib.cmd_valid = 1'b0; ib.op_code = 2'b00; ib.addr_bank = '0; ib.addr_col = '0; ib.data = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_sweep();
    test_out_of_range();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
